// File: rtl/ram_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between the CPU data port and the VGA screen fetcher.
// Screen wins by default; an aging counter bounds CPU wait. Optional one-entry screen cache: SCREEN_CACHE_EN.
module ram_port_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 9,
  parameter int MAX_CPU_WAIT = 4
) (
  input  logic                  CLK_50,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  scr_req,
  input  logic [ADDR_WIDTH-1:0] scr_addr,
  output logic                  scr_rvalid,
  output logic [DATA_WIDTH-1:0] scr_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_SCR} owner_e;

  localparam int WAIT_W = (MAX_CPU_WAIT > 0) ? $clog2(MAX_CPU_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_CPU_WAIT);

  owner_e                rd_owner_q, rd_owner_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0] cpu_hold_q, cpu_hold_d;
  logic [DATA_WIDTH-1:0] scr_hold_q, scr_hold_d;
  logic                  scr_hit_q, scr_hit_d;
  logic                  scr_hit, scr_need, cpu_gnt, scr_gnt;

`ifdef SCREEN_CACHE_EN
  logic                  cache_valid_q, cache_valid_d;
  logic [ADDR_WIDTH-1:0] cache_tag_q, cache_tag_d;
  logic [DATA_WIDTH-1:0] cache_data_q, cache_data_d;
  logic [ADDR_WIDTH-1:0] pend_tag_q, pend_tag_d;
`endif

  // Arbitration and RAM-side outputs; no grant is issued while reset is held.
  always_comb begin
    scr_hit = 1'b0;
`ifdef SCREEN_CACHE_EN
    scr_hit = ~reset & scr_req & cache_valid_q & (scr_addr == cache_tag_q);
`endif
    scr_need  = scr_req & ~scr_hit;
    cpu_gnt   = ~reset & cpu_req & (~scr_need | (wait_cnt_q >= WAIT_MAX));
    scr_gnt   = ~reset & scr_need & ~cpu_gnt;
    cpu_stall = cpu_req & ~cpu_gnt;
    mem_we    = cpu_gnt & cpu_we;
    mem_wdata = cpu_wdata;
    if (cpu_gnt)      mem_addr = cpu_addr;
    else if (scr_gnt) mem_addr = scr_addr;
    else              mem_addr = '0;
  end

  // Read-return side: live RAM data in the return cycle, otherwise the hold register.
  always_comb begin
    cpu_rvalid = ~reset & (rd_owner_q == OWN_CPU);
    scr_rvalid = ~reset & ((rd_owner_q == OWN_SCR) | scr_hit_q);
    if (reset)           cpu_rdata = '0;
    else if (cpu_rvalid) cpu_rdata = mem_rdata;
    else                 cpu_rdata = cpu_hold_q;
    if (reset)                        scr_rdata = '0;
    else if (rd_owner_q == OWN_SCR)   scr_rdata = mem_rdata;
`ifdef SCREEN_CACHE_EN
    else if (scr_hit_q)               scr_rdata = cache_data_q;
`endif
    else                              scr_rdata = scr_hold_q;
  end

  always_comb begin
    if (cpu_gnt & ~cpu_we) rd_owner_d = OWN_CPU;
    else if (scr_gnt)      rd_owner_d = OWN_SCR;
    else                   rd_owner_d = OWN_NONE;

    if (cpu_gnt | ~cpu_req)        wait_cnt_d = '0;
    else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
    else                           wait_cnt_d = wait_cnt_q;

    cpu_hold_d = cpu_rvalid ? cpu_rdata : cpu_hold_q;
    scr_hold_d = scr_rvalid ? scr_rdata : scr_hold_q;
    scr_hit_d  = scr_hit;
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state math lives in always_comb.
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      rd_owner_q <= OWN_NONE;
      wait_cnt_q <= '0;
      cpu_hold_q <= '0;
      scr_hold_q <= '0;
      scr_hit_q  <= 1'b0;
    end else begin
      rd_owner_q <= rd_owner_d;
      wait_cnt_q <= wait_cnt_d;
      cpu_hold_q <= cpu_hold_d;
      scr_hold_q <= scr_hold_d;
      scr_hit_q  <= scr_hit_d;
    end
  end

`ifdef SCREEN_CACHE_EN
  // Fill on every screen read return; a CPU write to the cached word (including one in the fill cycle) wins.
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;
    pend_tag_d    = scr_gnt ? scr_addr : pend_tag_q;
    if (~reset & (rd_owner_q == OWN_SCR)) begin
      cache_valid_d = 1'b1;
      cache_tag_d   = pend_tag_q;
      cache_data_d  = mem_rdata;
    end
    if (cpu_gnt & cpu_we & (cpu_addr == cache_tag_d)) cache_data_d = cpu_wdata;
  end

  always_ff @(posedge CLK_50) begin
    if (reset) cache_valid_q <= 1'b0;
    else       cache_valid_q <= cache_valid_d;
  end

  // NOTE: tag/data/pending-tag are storage qualified by cache_valid_q, so they carry no reset.
  always_ff @(posedge CLK_50) begin
    cache_tag_q  <= cache_tag_d;
    cache_data_q <= cache_data_d;
    pend_tag_q   <= pend_tag_d;
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: vector table plus contention, reset, MAX_CPU_WAIT=0 and cache sequences.
module tb_ram_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 9;

  logic          CLK_50 = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, scr_req;
  logic [AW-1:0] cpu_addr, scr_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall, cpu_rvalid, scr_rvalid, mem_we;
  logic [DW-1:0] cpu_rdata, scr_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic          cpu_stall0, cpu_rvalid0, scr_rvalid0, mem_we0;
  logic [DW-1:0] cpu_rdata0, scr_rdata0, mem_wdata0;
  logic [DW-1:0] mem_rdata0 = '0;
  logic [AW-1:0] mem_addr0;

  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] ram [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  always #10 CLK_50 = ~CLK_50;

  // Single-port synchronous RAM model with a preload port for the bench.
  always @(posedge CLK_50) begin
    if (ld_en)       ram[ld_addr] <= ld_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_CPU_WAIT(4)) u_dut (
    .CLK_50(CLK_50), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .scr_req(scr_req), .scr_addr(scr_addr), .scr_rvalid(scr_rvalid), .scr_rdata(scr_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_CPU_WAIT(0)) u_dut0 (
    .CLK_50(CLK_50), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall0), .cpu_rvalid(cpu_rvalid0), .cpu_rdata(cpu_rdata0),
    .scr_req(scr_req), .scr_addr(scr_addr), .scr_rvalid(scr_rvalid0), .scr_rdata(scr_rdata0),
    .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  typedef struct {
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          scr_req;
    logic [AW-1:0] scr_addr;
    logic          e_stall;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic          e_cpu_rv;
    logic          e_scr_rv;
    logic [DW-1:0] e_scr_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_50);
    #1;
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                       input logic [DW-1:0] cwd, input logic sreq, input logic [AW-1:0] saddr);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    scr_req = sreq; scr_addr = saddr;
  endtask

  initial begin
    int stalls, stall0_seen, granted;
    logic [AW-1:0] pre_a [5];
    logic [DW-1:0] pre_d [5];

    //            creq  cwe   caddr   cwdata    sreq  saddr   stall addr    we    cpurv srv   srdata
    vecs[0] = '{1'b0, 1'b0, 9'h000, 16'h0000, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 9'h010, 1'b0, 9'h010, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 9'h020, 16'h1234, 1'b0, 9'h000, 1'b0, 9'h020, 1'b1, 1'b0, 1'b1, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 9'h020, 1'b0, 9'h020, 1'b0, 1'b0, 1'b0, 16'hBEEF};
    vecs[4] = '{1'b0, 1'b0, 9'h000, 16'h0000, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 16'h1234};
    vecs[5] = '{1'b1, 1'b0, 9'h005, 16'h0000, 1'b1, 9'h010, 1'b1, 9'h010, 1'b0, 1'b0, 1'b0, 16'h1234};
    vecs[6] = '{1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 9'h011, 1'b0, 9'h011, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    vecs[7] = '{1'b1, 1'b0, 9'h005, 16'h0000, 1'b1, 9'h012, 1'b1, 9'h012, 1'b0, 1'b0, 1'b1, 16'h1111};
    vecs[8] = '{1'b0, 1'b0, 9'h000, 16'h0000, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 16'h2222};

    pre_a[0] = 9'h005; pre_d[0] = 16'hC0DE;
    pre_a[1] = 9'h010; pre_d[1] = 16'hBEEF;
    pre_a[2] = 9'h011; pre_d[2] = 16'h1111;
    pre_a[3] = 9'h012; pre_d[3] = 16'h2222;
    pre_a[4] = 9'h030; pre_d[4] = 16'h3030;

    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      ld_en = 1'b1; ld_addr = pre_a[i]; ld_data = pre_d[i];
      tick();
    end
    ld_en = 1'b0;
    @(negedge CLK_50);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_scr_rvalid", 32'(scr_rvalid), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    tick();
    reset = 1'b0;

    // Table of single-cycle vectors applied back to back.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].cpu_req, vecs[i].cpu_we, vecs[i].cpu_addr, vecs[i].cpu_wdata,
            vecs[i].scr_req, vecs[i].scr_addr);
      @(negedge CLK_50);
      check($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
      check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      check($sformatf("v%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].e_cpu_rv));
      check($sformatf("v%0d_scr_rvalid", i), 32'(scr_rvalid), 32'(vecs[i].e_scr_rv));
      check($sformatf("v%0d_scr_rdata", i), 32'(scr_rdata), 32'(vecs[i].e_scr_rdata));
      tick();
    end

    // Contention: CPU read vs continuous screen fetch; the MAX_CPU_WAIT=0 instance sees the same inputs.
    drive(1'b1, 1'b0, 9'h005, 16'h0, 1'b1, 9'h010);
    stalls = 0; granted = 0; stall0_seen = 0;
    for (int i = 0; i < 20 && granted == 0; i++) begin
      @(negedge CLK_50);
      if (i == 0) check("max0_mem_addr", 32'(mem_addr0), 32'h005);
      if (cpu_stall0) stall0_seen++;
      if (cpu_stall) stalls++;
      else begin
        granted = 1;
        check("cont_gnt_addr", 32'(mem_addr), 32'h005);
      end
      tick();
    end
    check("cont_granted", 32'(granted), 32'd1);
    check("cont_stalls", 32'(stalls), 32'd4);

    stalls = 0; granted = 0;
    for (int i = 0; i < 20 && granted == 0; i++) begin
      @(negedge CLK_50);
      if (i == 0) begin
        check("cont_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("cont_cpu_rdata", 32'(cpu_rdata), 32'hC0DE);
      end
      if (cpu_stall0) stall0_seen++;
      if (cpu_stall) stalls++;
      else granted = 1;
      tick();
    end
    check("cont2_granted", 32'(granted), 32'd1);
    check("cont2_stalls_after_clear", 32'(stalls), 32'd4);
    check("max0_never_stalled", 32'(stall0_seen), 32'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    tick();
    tick();

    // Reset asserted the cycle after a CPU read grant.
    drive(1'b1, 1'b0, 9'h005, 16'h0, 1'b0, '0);
    @(negedge CLK_50);
    check("prerst_gnt_addr", 32'(mem_addr), 32'h005);
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b1, 9'h010);
    @(negedge CLK_50);
    check("inrst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("inrst_scr_rvalid", 32'(scr_rvalid), 32'd0);
    check("inrst_mem_addr", 32'(mem_addr), 32'h0);
    check("inrst_mem_we", 32'(mem_we), 32'd0);
    check("inrst_cpu_rdata", 32'(cpu_rdata), 32'h0);
    check("inrst_scr_rdata", 32'(scr_rdata), 32'h0);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    @(negedge CLK_50);
    check("postrst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("postrst_cpu_hold", 32'(cpu_rdata), 32'h0);
    check("postrst_scr_hold", 32'(scr_rdata), 32'h0);
    tick();

    // Screen fetch, CPU write to the same word, screen fetch again.
    drive(1'b0, 1'b0, '0, '0, 1'b1, 9'h030);
    @(negedge CLK_50);
    check("c1_mem_addr", 32'(mem_addr), 32'h030);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    @(negedge CLK_50);
    check("c1_scr_rvalid", 32'(scr_rvalid), 32'd1);
    check("c1_scr_rdata", 32'(scr_rdata), 32'h3030);
    tick();
    drive(1'b1, 1'b1, 9'h030, 16'h5A5A, 1'b0, '0);
    @(negedge CLK_50);
    check("c_wr_mem_we", 32'(mem_we), 32'd1);
    check("c_wr_mem_addr", 32'(mem_addr), 32'h030);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 9'h030);
    @(negedge CLK_50);
`ifdef SCREEN_CACHE_EN
    check("c2_mem_addr_hit", 32'(mem_addr), 32'h0);
`else
    check("c2_mem_addr_miss", 32'(mem_addr), 32'h030);
`endif
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    @(negedge CLK_50);
    check("c2_scr_rvalid", 32'(scr_rvalid), 32'd1);
    check("c2_scr_rdata", 32'(scr_rdata), 32'h5A5A);
    tick();
    @(negedge CLK_50);
    check("c2_rvalid_one_cycle", 32'(scr_rvalid), 32'd0);
    check("c2_scr_hold", 32'(scr_rdata), 32'h5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
